// File: rtl/falling_sand_pkg.sv
// rtl/falling_sand_pkg.sv - shared types and constants for the falling sand brush writer
package falling_sand_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    PAINT,
    RELEASE
  } brush_state_t;

  localparam logic SAND  = 1'b1;
  localparam logic EMPTY = 1'b0;

  // Index of each direction button in the packed direction vectors.
  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

endpackage

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - 2-flop synchronizer plus registered rising-edge detect
module button_conditioner (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_rise;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= btn_i;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_rise  <= r_sync2 & ~r_prev;
    end
  end

  assign level_o = r_sync2;
  assign rise_o  = r_rise;

endmodule

// File: rtl/sand_brush_writer.sv
// rtl/sand_brush_writer.sv - button-driven cursor and square brush stamper for the game RAM
// Optional erase button enabled by defining BRUSH_ERASE_EN.
module sand_brush_writer
  import falling_sand_pkg::*;
#(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
  parameter int DATA_WIDTH     = 1,
  parameter int BRUSH_SIZE     = 4,
  parameter int MOVE_DIVIDER   = 1000000
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              btn_up_i,
  input  logic                              btn_down_i,
  input  logic                              btn_left_i,
  input  logic                              btn_right_i,
  input  logic                              btn_place_i,
`ifdef BRUSH_ERASE_EN
  input  logic                              btn_erase_i,
`endif
  input  logic                              grant_i,
  output logic                              wr_req_o,
  output logic                              wr_en_o,
  output logic [ADDR_WIDTH-1:0]             wr_address_o,
  output logic [DATA_WIDTH-1:0]             wr_data_o,
  output logic [$clog2(ACTIVE_COLUMNS)-1:0] cursor_x_o,
  output logic [$clog2(ACTIVE_ROWS)-1:0]    cursor_y_o,
  output logic                              busy_o
);

  localparam int XW = $clog2(ACTIVE_COLUMNS);
  localparam int YW = $clog2(ACTIVE_ROWS);
  localparam int BW = (BRUSH_SIZE > 1) ? $clog2(BRUSH_SIZE) : 1;
  localparam int CW = $clog2(MOVE_DIVIDER);

  localparam logic [XW-1:0]         X_RESET  = XW'(ACTIVE_COLUMNS / 2);
  localparam logic [XW-1:0]         X_MAX    = XW'(ACTIVE_COLUMNS - 1);
  localparam logic [YW-1:0]         Y_MAX    = YW'(ACTIVE_ROWS - 1);
  localparam logic [BW-1:0]         B_LAST   = BW'(BRUSH_SIZE - 1);
  localparam logic [CW-1:0]         REP_LAST = CW'(MOVE_DIVIDER - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(ACTIVE_COLUMNS);

  logic [3:0] w_btn;
  logic [3:0] w_level;
  logic [3:0] w_rise;
  logic [3:0] w_step;
  logic       w_place_rise;
  logic       w_unused_place_level;
  logic       w_start;

  assign w_btn = {btn_right_i, btn_left_i, btn_down_i, btn_up_i};

  for (genvar g = 0; g < 4; g++) begin : g_dir
    button_conditioner u_dir (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .btn_i   (w_btn[g]),
      .level_o (w_level[g]),
      .rise_o  (w_rise[g])
    );
  end

  button_conditioner u_place (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .btn_i   (btn_place_i),
    .level_o (w_unused_place_level),
    .rise_o  (w_place_rise)
  );

`ifdef BRUSH_ERASE_EN
  logic w_erase_rise;
  logic w_unused_erase_level;
  logic [DATA_WIDTH-1:0] r_wr_data;

  button_conditioner u_erase (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .btn_i   (btn_erase_i),
    .level_o (w_unused_erase_level),
    .rise_o  (w_erase_rise)
  );

  assign w_start   = w_place_rise | w_erase_rise;
  assign wr_data_o = r_wr_data;
`else
  assign w_start   = w_place_rise;
  assign wr_data_o = {DATA_WIDTH{SAND}};
`endif

  // Cursor: one step on the press edge, then one per MOVE_DIVIDER cycles while held.
  logic [XW-1:0] r_cursor_x;
  logic [YW-1:0] r_cursor_y;
  logic [CW-1:0] r_rep_cnt [4];

  always_comb begin
    w_step = '0;
    for (int i = 0; i < 4; i++) begin
      w_step[i] = w_rise[i] | (w_level[i] & (r_rep_cnt[i] == REP_LAST));
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cursor_x <= X_RESET;
      r_cursor_y <= '0;
      for (int i = 0; i < 4; i++) r_rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!w_level[i] || w_rise[i] || (r_rep_cnt[i] == REP_LAST)) r_rep_cnt[i] <= '0;
        else r_rep_cnt[i] <= r_rep_cnt[i] + 1'b1;
      end
      if (w_step[DIR_UP] && !w_level[DIR_DOWN] && (r_cursor_y != '0))
        r_cursor_y <= r_cursor_y - 1'b1;
      else if (w_step[DIR_DOWN] && !w_level[DIR_UP] && (r_cursor_y != Y_MAX))
        r_cursor_y <= r_cursor_y + 1'b1;
      if (w_step[DIR_LEFT] && !w_level[DIR_RIGHT] && (r_cursor_x != '0))
        r_cursor_x <= r_cursor_x - 1'b1;
      else if (w_step[DIR_RIGHT] && !w_level[DIR_LEFT] && (r_cursor_x != X_MAX))
        r_cursor_x <= r_cursor_x + 1'b1;
    end
  end

  // Stamp engine
  brush_state_t          r_state;
  logic [XW-1:0]         r_x0;
  logic [YW-1:0]         r_y0;
  logic [BW-1:0]         r_bx;
  logic [BW-1:0]         r_by;
  logic [ADDR_WIDTH-1:0] r_row_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_done;
  logic                  r_wr_req;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_address;
  logic                  r_busy;

  logic [ADDR_WIDTH-1:0] w_base;
  logic                  w_in_range;
  logic                  w_last_x;
  logic                  w_last_cell;
  logic                  w_emit;

  assign w_base      = ADDR_WIDTH'(int'(r_cursor_y) * ACTIVE_COLUMNS + int'(r_cursor_x));
  assign w_in_range  = ((int'(r_x0) + int'(r_bx)) < ACTIVE_COLUMNS) &&
                       ((int'(r_y0) + int'(r_by)) < ACTIVE_ROWS);
  assign w_last_x    = (r_bx == B_LAST);
  assign w_last_cell = w_last_x && (r_by == B_LAST);
  // The grant that moves REQUEST to PAINT already paints the first cell.
  assign w_emit      = grant_i && ((r_state == REQUEST) || ((r_state == PAINT) && !r_done));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= IDLE;
      r_x0         <= '0;
      r_y0         <= '0;
      r_bx         <= '0;
      r_by         <= '0;
      r_row_addr   <= '0;
      r_addr       <= '0;
      r_done       <= 1'b0;
      r_wr_req     <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_address <= '0;
      r_busy       <= 1'b0;
`ifdef BRUSH_ERASE_EN
      r_wr_data    <= {DATA_WIDTH{SAND}};
`endif
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_x0       <= r_cursor_x;
            r_y0       <= r_cursor_y;
            r_row_addr <= w_base;
            r_addr     <= w_base;
            r_bx       <= '0;
            r_by       <= '0;
            r_done     <= 1'b0;
            r_wr_req   <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= REQUEST;
`ifdef BRUSH_ERASE_EN
            r_wr_data  <= w_place_rise ? {DATA_WIDTH{SAND}} : {DATA_WIDTH{EMPTY}};
`endif
          end
        end
        REQUEST: begin
          if (grant_i) r_state <= PAINT;
        end
        PAINT: begin
          if (r_done) begin
            r_wr_req <= 1'b0;
            r_state  <= RELEASE;
          end
        end
        RELEASE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_emit) begin
        r_wr_en      <= w_in_range;
        r_wr_address <= r_addr;
        if (w_last_cell) begin
          r_done <= 1'b1;
        end else if (w_last_x) begin
          r_bx       <= '0;
          r_by       <= r_by + 1'b1;
          r_row_addr <= r_row_addr + ROW_STEP;
          r_addr     <= r_row_addr + ROW_STEP;
        end else begin
          r_bx   <= r_bx + 1'b1;
          r_addr <= r_addr + 1'b1;
        end
      end
    end
  end

  assign wr_req_o     = r_wr_req;
  assign wr_en_o      = r_wr_en;
  assign wr_address_o = r_wr_address;
  assign busy_o       = r_busy;
  assign cursor_x_o   = r_cursor_x;
  assign cursor_y_o   = r_cursor_y;

endmodule

// File: tb/tb_sand_brush_writer.sv
// tb/tb_sand_brush_writer.sv - scoreboard bench for sand_brush_writer
module tb_sand_brush_writer;

  localparam int COLS = 640;
  localparam int ROWS = 480;
  localparam int BS   = 4;
  localparam int MD   = 4;
  localparam int AW   = $clog2(COLS * ROWS);

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    btn;
  logic          place;
  logic          grant;
`ifdef BRUSH_ERASE_EN
  logic          erase;
`endif
  logic          wr_req;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [0:0]    wr_data;
  logic [9:0]    cursor_x;
  logic [8:0]    cursor_y;
  logic          busy;

  always #5 clk = ~clk;

  sand_brush_writer #(
    .ACTIVE_COLUMNS (COLS),
    .ACTIVE_ROWS    (ROWS),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (1),
    .BRUSH_SIZE     (BS),
    .MOVE_DIVIDER   (MD)
  ) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .btn_up_i     (btn[0]),
    .btn_down_i   (btn[1]),
    .btn_left_i   (btn[2]),
    .btn_right_i  (btn[3]),
    .btn_place_i  (place),
`ifdef BRUSH_ERASE_EN
    .btn_erase_i  (erase),
`endif
    .grant_i      (grant),
    .wr_req_o     (wr_req),
    .wr_en_o      (wr_en),
    .wr_address_o (wr_addr),
    .wr_data_o    (wr_data),
    .cursor_x_o   (cursor_x),
    .cursor_y_o   (cursor_y),
    .busy_o       (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_wr     = 0;

  typedef struct {
    int addr;
    int data;
  } wr_t;
  wr_t exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic push_stamp(input int x0, input int y0, input int d);
    wr_t e;
    for (int by = 0; by < BS; by++)
      for (int bx = 0; bx < BS; bx++)
        if (x0 + bx < COLS && y0 + by < ROWS) begin
          e.addr = (y0 + by) * COLS + x0 + bx;
          e.data = d;
          exp_q.push_back(e);
        end
  endtask

  always @(negedge clk) begin
    if (!rst && wr_en) begin
      wr_t e;
      n_wr++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", int'(wr_addr), -1);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", int'(wr_addr), e.addr);
        check("wr_data", int'(wr_data), e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tap(input int idx);
    btn[idx] = 1'b1;
    tick();
    btn[idx] = 1'b0;
    repeat (4) tick();
  endtask

  task automatic hold_until(input int idx, input bit is_x, input int target, input int bound);
    int i = 0;
    btn[idx] = 1'b1;
    while (((is_x ? int'(cursor_x) : int'(cursor_y)) != target) && i < bound) begin
      tick();
      i++;
    end
    repeat (8) tick();
    btn[idx] = 1'b0;
    repeat (4) tick();
    check(is_x ? "hold_x" : "hold_y", is_x ? int'(cursor_x) : int'(cursor_y), target);
  endtask

  task automatic wait_req(input int bound);
    int i = 0;
    while (!wr_req && i < bound) begin
      tick();
      i++;
    end
    check("req_wait", int'(wr_req), 1);
  endtask

  task automatic wait_idle(input int bound);
    int i = 0;
    while (busy && i < bound) begin
      tick();
      i++;
    end
    check("idle_wait", int'(busy), 0);
  endtask

  task automatic count_req_cycles(input string tag);
    int c = 1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (wr_req) c++;
      else break;
    end
    check(tag, c, BS * BS + 1);
  endtask

  task automatic pulse_place();
    place = 1'b1;
    tick();
    place = 1'b0;
  endtask

  initial begin
    int n0, prev, changes, first_v, second_v;
    rst = 1'b1;
    btn = '0;
    place = 1'b0;
    grant = 1'b0;
`ifdef BRUSH_ERASE_EN
    erase = 1'b0;
`endif
    repeat (3) tick();
    check("rst_wr_req", int'(wr_req), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 1);
    check("rst_cursor_x", int'(cursor_x), 320);
    check("rst_cursor_y", int'(cursor_y), 0);
    rst = 1'b0;
    tick();

    // Full stamp at reset cursor with grant tied high
    grant = 1'b1;
    push_stamp(320, 0, 1);
    n0 = n_wr;
    pulse_place();
    tick();
    check("lat_req_n1", int'(wr_req), 0);
    tick();
    check("lat_req_n2", int'(wr_req), 0);
    tick();
    check("lat_req_n3", int'(wr_req), 1);
    check("lat_busy_n3", int'(busy), 1);
    count_req_cycles("req_cycles_full");
    wait_idle(50);
    check("full_writes", n_wr - n0, 16);
    check("full_queue", exp_q.size(), 0);

    // Opposite directions held together cancel
    btn[2] = 1'b1;
    btn[3] = 1'b1;
    repeat (12) tick();
    btn = '0;
    repeat (4) tick();
    check("lr_cancel_x", int'(cursor_x), 320);
    btn[0] = 1'b1;
    repeat (12) tick();
    btn = '0;
    repeat (4) tick();
    check("up_sat_y", int'(cursor_y), 0);

    hold_until(2, 1'b1, 0, 2000);
    tap(3);
    tap(3);
    check("tap_x", int'(cursor_x), 2);
    btn[2] = 1'b1;
    prev = 2;
    changes = 0;
    first_v = -1;
    second_v = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (int'(cursor_x) != prev) begin
        changes++;
        if (changes == 1) first_v = int'(cursor_x);
        if (changes == 2) second_v = int'(cursor_x);
        prev = int'(cursor_x);
      end
    end
    btn[2] = 1'b0;
    repeat (4) tick();
    check("left_first", first_v, 1);
    check("left_second", second_v, 0);
    check("left_changes", changes, 2);
    check("left_final", int'(cursor_x), 0);

    // Corner stamp with clipping
    hold_until(3, 1'b1, 639, 4000);
    tap(2);
    hold_until(1, 1'b0, 479, 3000);
    tap(0);
    check("corner_x", int'(cursor_x), 638);
    check("corner_y", int'(cursor_y), 478);
    push_stamp(638, 478, 1);
    n0 = n_wr;
    pulse_place();
    wait_req(10);
    count_req_cycles("req_cycles_clip");
    wait_idle(50);
    check("clip_writes", n_wr - n0, 4);
    check("clip_queue", exp_q.size(), 0);

    // Reset during the 8th PAINT cycle
    repeat (3) tap(2);
    check("pre_rst_x", int'(cursor_x), 635);
    push_stamp(635, 478, 1);
    pulse_place();
    wait_req(10);
    repeat (8) tick();
    check("paint8_wr_en", int'(wr_en), 1);
    check("paint8_addr", int'(wr_addr), 479 * COLS + 638);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_wr_en", int'(wr_en), 0);
    check("mid_rst_wr_req", int'(wr_req), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_x", int'(cursor_x), 320);
    check("mid_rst_y", int'(cursor_y), 0);
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    grant = 1'b0;
    tick();

    // Grant withheld, then 5 granted cycles, 3-cycle pause, regrant
    push_stamp(320, 0, 1);
    n0 = n_wr;
    pulse_place();
    tick();
    tick();
    check("ng_req_n2", int'(wr_req), 0);
    tick();
    check("ng_req_n3", int'(wr_req), 1);
    changes = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wr_req && !wr_en) changes++;
    end
    check("ng_hold", changes, 6);
    check("ng_no_writes", n_wr - n0, 0);
    grant = 1'b1;
    repeat (5) tick();
    grant = 1'b0;
    changes = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (!wr_en) changes++;
    end
    check("pause_idle", changes, 3);
    check("pause_writes", n_wr - n0, 5);
    grant = 1'b1;
    wait_idle(60);
    check("regrant_writes", n_wr - n0, 16);
    check("regrant_queue", exp_q.size(), 0);

`ifdef BRUSH_ERASE_EN
    push_stamp(320, 0, 0);
    n0 = n_wr;
    erase = 1'b1;
    tick();
    erase = 1'b0;
    wait_req(10);
    wait_idle(60);
    check("erase_writes", n_wr - n0, 16);
    check("erase_queue", exp_q.size(), 0);
    push_stamp(320, 0, 1);
    n0 = n_wr;
    place = 1'b1;
    erase = 1'b1;
    tick();
    place = 1'b0;
    erase = 1'b0;
    wait_req(10);
    wait_idle(60);
    check("both_writes", n_wr - n0, 16);
    check("both_queue", exp_q.size(), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
